// File: rtl/fir_pkg.sv
// Shared types and fixed-point helpers for the complex FIR family.
// Used by both the interpolating and the decimating filters.
package fir_pkg;

    typedef enum logic [1:0] {
        LOAD,
        MAC,
        WRITE
    } fir_interp_state_t;

    localparam int MAX_W = 64;

    // Full-precision signed product, arithmetic shift, keep the low MAX_W bits.
    function automatic logic signed [MAX_W-1:0] scaled_prod(
        input logic signed [MAX_W-1:0] a,
        input logic signed [MAX_W-1:0] b,
        input int frac
    );
        logic signed [2*MAX_W-1:0] p;
        p = (2*MAX_W)'(a) * (2*MAX_W)'(b);
        p = p >>> frac;
        return p[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/cmplx_mac.sv
// Combinational complex multiply with fixed-point rescale.
// Products are truncated to DATA_WIDTH; the sums wrap.
module cmplx_mac
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10
) (
    input  logic [DATA_WIDTH-1:0] hr,
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [DATA_WIDTH-1:0] xr,
    input  logic [DATA_WIDTH-1:0] xi,
    output logic [DATA_WIDTH-1:0] pr,
    output logic [DATA_WIDTH-1:0] pi
);

    if (DATA_WIDTH > MAX_W) begin : g_bad_width
        $error("cmplx_mac: DATA_WIDTH exceeds MAX_W");
    end

    function automatic logic [DATA_WIDTH-1:0] mul(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic signed [MAX_W-1:0] p;
        p = scaled_prod(MAX_W'($signed(a)), MAX_W'($signed(b)), FRAC_BITS);
        return p[DATA_WIDTH-1:0];
    endfunction

    assign pr = mul(hr, xr) - mul(hi, xi);
    assign pi = mul(hr, xi) + mul(hi, xr);

endmodule

// File: rtl/fir_cmplx_interp.sv
// Polyphase interpolating complex FIR: one input sample yields INTERP outputs,
// each phase computed one complex tap per cycle through a shared cmplx_mac.
module fir_cmplx_interp
    import fir_pkg::*;
#(
    parameter int INTERP     = 4,
    parameter int TAPS       = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter logic signed [0:TAPS-1][DATA_WIDTH-1:0] h_real = '0,
    parameter logic signed [0:TAPS-1][DATA_WIDTH-1:0] h_imag = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] x_real_in,
    input  logic [DATA_WIDTH-1:0] x_imag_in,
    input  logic                  x_real_in_empty,
    input  logic                  x_imag_in_empty,
    output logic                  x_real_in_rd_en,
    output logic                  x_imag_in_rd_en,
    output logic [DATA_WIDTH-1:0] y_real_out,
    output logic [DATA_WIDTH-1:0] y_imag_out,
    input  logic                  y_real_out_full,
    input  logic                  y_imag_out_full,
    output logic                  y_real_out_wr_en,
    output logic                  y_imag_out_wr_en
);

    localparam int P  = TAPS / INTERP;
    localparam int KW = (P > 1) ? $clog2(P) : 1;
    localparam int PW = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;

    if (TAPS % INTERP != 0) begin : g_bad_taps
        $error("fir_cmplx_interp: TAPS must be a multiple of INTERP");
    end

    fir_interp_state_t state;
    logic [KW-1:0] k;
    logic [PW-1:0] phase;
    logic [DATA_WIDTH-1:0] hist_re [P];
    logic [DATA_WIDTH-1:0] hist_im [P];
    logic [DATA_WIDTH-1:0] acc_re, acc_im;

    logic rd_en, wr_en;
    logic [IW-1:0] h_idx;
    logic [DATA_WIDTH-1:0] hr, hi, xr, xi, pr, pi;
    logic [DATA_WIDTH-1:0] acc_re_nxt, acc_im_nxt;

    assign rd_en = (state == LOAD) && !x_real_in_empty && !x_imag_in_empty;
    assign wr_en = (state == WRITE) && !y_real_out_full && !y_imag_out_full;

    assign x_real_in_rd_en  = rd_en;
    assign x_imag_in_rd_en  = rd_en;
    assign y_real_out_wr_en = wr_en;
    assign y_imag_out_wr_en = wr_en;

    // Phase p of output uses every INTERP-th prototype tap starting at p.
    assign h_idx = IW'(int'(k) * INTERP + int'(phase));
    assign hr    = h_real[h_idx];
    assign hi    = h_imag[h_idx];
    assign xr    = hist_re[k];
    assign xi    = hist_im[k];

    cmplx_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .hr (hr),
        .hi (hi),
        .xr (xr),
        .xi (xi),
        .pr (pr),
        .pi (pi)
    );

    assign acc_re_nxt = ((k == '0) ? '0 : acc_re) + pr;
    assign acc_im_nxt = ((k == '0) ? '0 : acc_im) + pi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            k          <= '0;
            phase      <= '0;
            acc_re     <= '0;
            acc_im     <= '0;
            y_real_out <= '0;
            y_imag_out <= '0;
            for (int j = 0; j < P; j++) begin
                hist_re[j] <= '0;
                hist_im[j] <= '0;
            end
        end else begin
            unique case (state)
                LOAD: begin
                    if (rd_en) begin
                        for (int j = P - 1; j > 0; j--) begin
                            hist_re[j] <= hist_re[j-1];
                            hist_im[j] <= hist_im[j-1];
                        end
                        hist_re[0] <= x_real_in;
                        hist_im[0] <= x_imag_in;
                        phase      <= '0;
                        k          <= '0;
                        state      <= MAC;
                    end
                end
                MAC: begin
                    acc_re <= acc_re_nxt;
                    acc_im <= acc_im_nxt;
                    if (k == KW'(P - 1)) begin
                        y_real_out <= acc_re_nxt;
                        y_imag_out <= acc_im_nxt;
                        state      <= WRITE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_en) begin
                        k <= '0;
                        if (phase == PW'(INTERP - 1)) begin
                            state <= LOAD;
                        end else begin
                            phase <= phase + 1'b1;
                            state <= MAC;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_cmplx_interp.sv
// Scoreboard bench: three filter instances (impulse, complex, wrap coefficient
// sets) fed from per-instance stimulus queues, outputs checked by a monitor.
module tb_fir_cmplx_interp;

    localparam int DW   = 32;
    localparam int NDUT = 3;

    localparam logic [0:7][DW-1:0] H_IMP = {
        32'd1024, 32'd2048, 32'd3072, 32'd4096,
        32'd5120, 32'd6144, 32'd7168, 32'd8192
    };
    localparam logic [0:7][DW-1:0] H_CPX_I = {32'd1024, {7{32'd0}}};
    localparam logic [0:1][DW-1:0] H_WRAP  = {32'd1024, 32'd1024};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] xr [NDUT];
    logic [DW-1:0] xi [NDUT];
    logic          er [NDUT];
    logic          ei [NDUT];
    logic          fr [NDUT];
    logic          fi [NDUT];
    logic          block_i [NDUT];
    logic [DW-1:0] yr [NDUT];
    logic [DW-1:0] yi [NDUT];
    logic          rdr [NDUT];
    logic          rdi [NDUT];
    logic          wr [NDUT];
    logic          wi [NDUT];

    logic [63:0] sq [NDUT][$];
    logic [63:0] eq [NDUT][$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    fir_cmplx_interp #(
        .INTERP(4), .TAPS(8), .DATA_WIDTH(DW), .FRAC_BITS(10),
        .h_real(H_IMP), .h_imag('0)
    ) u_imp (
        .clk(clk), .rst_n(rst_n),
        .x_real_in(xr[0]), .x_imag_in(xi[0]),
        .x_real_in_empty(er[0]), .x_imag_in_empty(ei[0]),
        .x_real_in_rd_en(rdr[0]), .x_imag_in_rd_en(rdi[0]),
        .y_real_out(yr[0]), .y_imag_out(yi[0]),
        .y_real_out_full(fr[0]), .y_imag_out_full(fi[0]),
        .y_real_out_wr_en(wr[0]), .y_imag_out_wr_en(wi[0])
    );

    fir_cmplx_interp #(
        .INTERP(4), .TAPS(8), .DATA_WIDTH(DW), .FRAC_BITS(10),
        .h_real('0), .h_imag(H_CPX_I)
    ) u_cpx (
        .clk(clk), .rst_n(rst_n),
        .x_real_in(xr[1]), .x_imag_in(xi[1]),
        .x_real_in_empty(er[1]), .x_imag_in_empty(ei[1]),
        .x_real_in_rd_en(rdr[1]), .x_imag_in_rd_en(rdi[1]),
        .y_real_out(yr[1]), .y_imag_out(yi[1]),
        .y_real_out_full(fr[1]), .y_imag_out_full(fi[1]),
        .y_real_out_wr_en(wr[1]), .y_imag_out_wr_en(wi[1])
    );

    fir_cmplx_interp #(
        .INTERP(1), .TAPS(2), .DATA_WIDTH(DW), .FRAC_BITS(10),
        .h_real(H_WRAP), .h_imag('0)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .x_real_in(xr[2]), .x_imag_in(xi[2]),
        .x_real_in_empty(er[2]), .x_imag_in_empty(ei[2]),
        .x_real_in_rd_en(rdr[2]), .x_imag_in_rd_en(rdi[2]),
        .y_real_out(yr[2]), .y_imag_out(yi[2]),
        .y_real_out_full(fr[2]), .y_imag_out_full(fi[2]),
        .y_real_out_wr_en(wr[2]), .y_imag_out_wr_en(wi[2])
    );

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Models an FWFT FIFO pair: head of sq[i] is presented while non-empty.
    task automatic feeder(input int i);
        logic pop;
        xr[i] = '0;
        xi[i] = '0;
        er[i] = 1'b1;
        ei[i] = 1'b1;
        forever begin
            @(negedge clk);
            pop = rst_n && rdr[i];
            @(posedge clk);
            #1;
            if (pop && sq[i].size() > 0) void'(sq[i].pop_front());
            if (sq[i].size() > 0) begin
                xr[i] = sq[i][0][63:32];
                xi[i] = sq[i][0][31:0];
                er[i] = 1'b0;
                ei[i] = block_i[i];
            end else begin
                er[i] = 1'b1;
                ei[i] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NDUT; i++) begin
                if (rdr[i] !== rdi[i] || wr[i] !== wi[i]) begin
                    errors++;
                    $display("FAIL pair%0d rd %b/%b wr %b/%b",
                             i, rdr[i], rdi[i], wr[i], wi[i]);
                end
                if (wr[i]) begin
                    checks++;
                    if (eq[i].size() == 0) begin
                        errors++;
                        $display("FAIL out%0d unexpected got %h_%h",
                                 i, yr[i], yi[i]);
                    end else begin
                        logic [63:0] e;
                        e = eq[i].pop_front();
                        if ({yr[i], yi[i]} !== e) begin
                            errors++;
                            $display("FAIL out%0d got %h_%h want %h_%h",
                                     i, yr[i], yi[i], e[63:32], e[31:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_rd(input int i, output int at);
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rdr[i]) begin
                at = cyc;
                return;
            end
        end
        errors++;
        $display("FAIL rd_timeout%0d got none want rd_en", i);
    endtask

    task automatic wait_wr(input int i, output int at);
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (wr[i]) begin
                at = cyc;
                return;
            end
        end
        errors++;
        $display("FAIL wr_timeout%0d got none want wr_en", i);
    endtask

    task automatic wait_drain(input int i);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (eq[i].size() == 0) begin
                @(negedge clk);
                return;
            end
        end
        errors++;
        $display("FAIL drain%0d got %0d left want 0", i, eq[i].size());
        eq[i].delete();
    endtask

    // Impulse then two zeros: 8 taps of response, then a flush phase of zeros.
    task automatic push_impulse(input int i);
        sq[i].push_back({32'd1024, 32'd0});
        sq[i].push_back(64'd0);
        sq[i].push_back(64'd0);
        for (int n = 1; n <= 8; n++) eq[i].push_back({32'(n * 1024), 32'd0});
        for (int n = 0; n < 4; n++) eq[i].push_back(64'd0);
    endtask

    int t0, t1;

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            fr[i] = 1'b0;
            fi[i] = 1'b0;
            block_i[i] = 1'b0;
        end
        fork
            feeder(0);
            feeder(1);
            feeder(2);
        join_none

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check("rst_y", {yr[i], yi[i]}, 64'd0);
            check("rst_en", {60'd0, rdr[i], rdi[i], wr[i], wi[i]}, 64'd0);
        end
        rst_n = 1'b1;

        push_impulse(0);
        wait_rd(0, t0);
        wait_wr(0, t1);
        check("latency", 64'(t1 - t0), 64'd3);
        wait_drain(0);

        fr[0] = 1'b1;
        fi[0] = 1'b1;
        push_impulse(0);
        wait_rd(0, t0);
        repeat (3) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check("bp_en", {60'd0, rdr[0], rdi[0], wr[0], wi[0]}, 64'd0);
            check("bp_y", {yr[0], yi[0]}, {32'd1024, 32'd0});
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        fr[0] = 1'b0;
        fi[0] = 1'b0;
        wait_drain(0);

        block_i[0] = 1'b1;
        push_impulse(0);
        @(posedge clk);
        #2;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("starve_en", {60'd0, rdr[0], rdi[0], wr[0], wi[0]}, 64'd0);
        end
        block_i[0] = 1'b0;
        wait_rd(0, t0);
        check("starve_pop", {32'd0, xr[0]}, {32'd0, 32'd1024});
        wait_drain(0);

        sq[0].push_back({32'd1024, 32'd0});
        sq[0].push_back({32'd1024, 32'd0});
        for (int n = 1; n <= 4; n++) eq[0].push_back({32'(n * 1024), 32'd0});
        wait_rd(0, t0);
        wait_rd(0, t1);
        check("throughput", 64'(t1 - t0), 64'd13);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_y", {yr[0], yi[0]}, {32'd4096, 32'd0});
        rst_n = 1'b0;
        #1;
        check("midrst_y", {yr[0], yi[0]}, 64'd0);
        check("midrst_en", {60'd0, rdr[0], rdi[0], wr[0], wi[0]}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_impulse(0);
        wait_drain(0);

        sq[1].push_back({32'd0, 32'd1024});
        eq[1].push_back({32'hFFFF_FC00, 32'd0});
        for (int n = 0; n < 3; n++) eq[1].push_back(64'd0);
        wait_drain(1);

        sq[2].push_back({32'h7FFF_FFFF, 32'd0});
        sq[2].push_back({32'h7FFF_FFFF, 32'd0});
        eq[2].push_back({32'h7FFF_FFFF, 32'd0});
        eq[2].push_back({32'hFFFF_FFFE, 32'd0});
        wait_drain(2);

        for (int i = 0; i < NDUT; i++) check("leftover", 64'(eq[i].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_cmplx_interp.md
# fir_cmplx_interp

Complex-coefficient polyphase interpolating FIR, the upsampling counterpart of the team's decimating complex FIR. It consumes one complex sample from a pair of FWFT input FIFOs and emits INTERP filtered complex samples into a pair of output FIFOs. It sits on the transmit/upsampling path, with FIFO handshakes on both sides identical to those of the decimating filter.

## Interface
- INTERP, 4: upsampling factor L, ≥1; outputs per input sample.
- TAPS, 32: prototype filter length; must be a multiple of INTERP; elaboration error otherwise.
- DATA_WIDTH, 32: sample, coefficient and accumulator width, signed.
- FRAC_BITS, 10: fixed-point fraction bits of samples and coefficients.
- h_real, h_imag, none: signed [0:TAPS-1][DATA_WIDTH-1:0] prototype coefficients.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- x_real_in, x_imag_in  in  DATA_WIDTH  FWFT FIFO head data, valid while !empty.
- x_real_in_empty, x_imag_in_empty  in  1  input FIFO empty.
- x_real_in_rd_en, x_imag_in_rd_en  out  1  pop; always asserted together.
- y_real_out, y_imag_out  out  DATA_WIDTH  output sample, registered.
- y_real_out_full, y_imag_out_full  in  1  output FIFO full.
- y_real_out_wr_en, y_imag_out_wr_en  out  1  push; always asserted together.

## Operation
- P = TAPS/INTERP taps per phase. History shift register x[0:P-1], x[0] newest.
- States: LOAD, MAC, WRITE.
- LOAD: when both empties are low, assert both rd_en for one cycle, shift history, set x[0] = input, set phase=0 and k=0, go to MAC. Otherwise wait and assert no rd_en.
- MAC: one complex tap per cycle, with k from 0 to P-1 and h = h[k*INTERP+phase]. re += (hr·xr − hi·xi), im += (hr·xi + hi·xr). Accumulator loads, rather than adds, at k=0. After k=P-1, go to WRITE.
- Arithmetic: each product at 2·DATA_WIDTH bits, arithmetic right shift by FRAC_BITS, truncate to DATA_WIDTH. Sums wrap modulo 2^DATA_WIDTH with no saturation.
- WRITE: y_* hold the accumulator. When both fulls are low, assert both wr_en for one cycle, then increment phase. If phase becomes INTERP, go to LOAD; else go to MAC with k=0.
- Boundary cases:
  - Only one empty low: treat as empty.
  - Only one full low: treat as full.
  - Full during WRITE: stall indefinitely; y_* and history stable; no rd_en.
  - INTERP=1: behaves as a plain complex FIR.
- Reset, including mid-operation: state=LOAD, history=0, accumulators=0, phase=k=0, y_*=0, rd_en=wr_en=0. Any partial output is discarded.

## Timing
- rd_en and wr_en are combinational from state and the empty/full flags.
- y_* are registered and updated at the end of the last MAC cycle.
- Cycle 0: LOAD pop. Cycles 1..P: MAC. Cycle P+1: first WRITE. First-output latency is P+1 cycles.
- Each further phase costs P+1 cycles with no backpressure. Throughput is 1 input per INTERP·(P+1)+1 cycles.
- No simultaneous read and write.
- Inputs are sampled on the rd_en cycle.

## Structure
- Package fir_pkg holds:
  - the fir_interp_state_t enum {LOAD, MAC, WRITE};
  - a helper function for the scaled, truncated product shared with the decimating filter.
- Sub-module cmplx_mac: combinational complex multiply plus FRAC_BITS scaling. Inputs hr, hi, xr, xi; outputs pr, pi. It is instantiated once, and the same unit can be reused by the decimator.

## Test plan
All scenarios use INTERP=4, TAPS=8, FRAC_BITS=10, DATA_WIDTH=32 unless stated.
- Impulse: feed 1024+0j then 0+0j, with h_real=1024·{1..8} and h_imag=0. Required: 8 outputs with real = 1024·{1,2,…,8} and imag = 0, the first wr_en 3 cycles after the first rd_en.
- Complex product: h_real=0, h_imag[0]=1024, input 0+1024j. Required: first output −1024+0j, remaining three outputs 0.
- Backpressure: hold fulls high for 5 cycles at the first WRITE. Required: wr_en low, y_* stable, no rd_en, and the output sequence is identical to the impulse case.
- Starvation and mismatch: x_imag_in_empty high while x_real_in_empty is low for 10 cycles. Required: no rd_en, no wr_en. On release, a normal pop.
- Reset mid-MAC: assert rst_n low during the second MAC cycle. Required: all outputs 0 immediately. After release, a 1024 impulse reproduces the impulse case exactly, with no residue from the earlier history.
- Wrap: with INTERP=1, TAPS=2, h_real={1024,1024}, feed two inputs of 0x7FFFFFFF. Required: the second output wraps to 0xFFFFFFFE.
